kbd_frame_rx: RTL and testbench

KBD_FRAME_RX -- requirements
Module: kbd_frame_rx

---
 rtl/kbd_pkg.sv | 5 +
 rtl/kbd_sync_filter.sv | 33 +++
 rtl/kbd_frame_rx.sv | 153 +++++++++++++++
 tb/tb_kbd_frame_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types for the PS/2 keyboard frame receiver: parity selection and FSM states.
package kbd_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_mode_t;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, CHECK} state_t;
endpackage

// File: rtl/kbd_sync_filter.sv
// 2-FF synchroniser followed by a run-length glitch filter for one PS/2 line.
module kbd_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt tracks how many consecutive synchronised samples disagree with filt
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/kbd_frame_rx.sv
// PS/2 device-to-host frame receiver: filtered line sampling, frame FSM with
// parity/stop/timeout checking, and an inline output FIFO.
module kbd_frame_rx
  import kbd_pkg::*;
#(
  parameter int           DATA_BITS      = 8,
  parameter parity_mode_t PARITY_MODE    = PAR_ODD,
  parameter int           FILTER_LEN     = 4,
  parameter int           TIMEOUT_CYCLES = 50000,
  parameter int           FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kbd_clk,
  input  logic                          kbd_dat,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = PW + 1;
  localparam int BW   = $clog2(DATA_BITS);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_f, dat_f, clk_prev, fall;

  kbd_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .raw(kbd_clk), .filt(clk_f));
  kbd_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .reset(reset), .raw(kbd_dat), .filt(dat_f));

  always_ff @(posedge clk) begin
    if (reset) clk_prev <= 1'b1;
    else       clk_prev <= clk_f;
  end
  assign fall = clk_prev & ~clk_f;

  state_t               state;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] sh;
  logic [TW-1:0]        tmo;
  logic                 par_bit, stop_bit;
  logic                 par_ok;

  always_comb begin
    par_ok = 1'b1;
    if (PARITY_MODE == PAR_ODD)  par_ok = (^sh ^ par_bit) == 1'b1;
    if (PARITY_MODE == PAR_EVEN) par_ok = (^sh ^ par_bit) == 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bcnt       <= '0;
      sh         <= '0;
      tmo        <= '0;
      par_bit    <= 1'b0;
      stop_bit   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          tmo <= '0;
          if (fall) begin
            if (!dat_f) begin
              state <= DATA;
              bcnt  <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        DATA, PARITY, STOP: begin
          if (fall) begin
            tmo <= '0;
            if (state == DATA) begin
              sh <= {dat_f, sh[DATA_BITS-1:1]};
              if (bcnt == BW'(DATA_BITS - 1))
                state <= (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
              else
                bcnt <= bcnt + 1'b1;
            end else if (state == PARITY) begin
              par_bit <= dat_f;
              state   <= STOP;
            end else begin
              stop_bit <= dat_f;
              state    <= CHECK;
            end
          end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            // line went quiet mid-frame: drop whatever was collected
            frame_err <= 1'b1;
            state     <= IDLE;
            tmo       <= '0;
            sh        <= '0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (!stop_bit)    frame_err  <= 1'b1;
          else if (!par_ok) parity_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop, full, wr_en;

  assign push  = (state == CHECK) && stop_bit && par_ok;
  assign pop   = dout_valid && dout_ready;
  assign full  = (fifo_count == NW'(FIFO_DEPTH));
  // a full FIFO still takes the word if the head leaves in the same cycle
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && !wr_en) overflow <= 1'b1;
    end
  end

  assign dout_valid = (fifo_count != '0);
  assign dout       = mem[rd_ptr];
endmodule

// File: tb/tb_kbd_frame_rx.sv
// Scoreboard bench for kbd_frame_rx: stimulus pushes expected words/errors,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_kbd_frame_rx;
  import kbd_pkg::*;

  logic       clk = 1'b0, reset = 1'b1;
  logic       kbd_clk = 1'b1, kbd_dat = 1'b1, dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, parity_err, frame_err, overflow, busy;
  logic [2:0] fifo_count;

  kbd_frame_rx #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .reset(reset), .kbd_clk(kbd_clk), .kbd_dat(kbd_dat),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .busy(busy), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  int         err_q[$];   // 1 = parity_err, 2 = frame_err

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (parity_err && frame_err) chk("both_err_pulses", 1, 0);
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", int'(dout), -1);
          else chk("dout_word", int'(dout), int'(exp_q.pop_front()));
        end
        if (parity_err) begin
          if (err_q.size() == 0) chk("unexpected_parity_err", 1, 0);
          else chk("parity_err_kind", 1, err_q.pop_front());
        end
        if (frame_err) begin
          if (err_q.size() == 0) chk("unexpected_frame_err", 2, 0);
          else chk("frame_err_kind", 2, err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // bits[0] goes first; returns right after the last kbd_clk fall is driven
  task automatic send_raw(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) begin tick(10); kbd_clk = 1'b1; end
      kbd_dat = bits[i];
      tick(10);
      kbd_clk = 1'b0;
    end
  endtask

  task automatic release_line();
    tick(10);
    kbd_clk = 1'b1;
    kbd_dat = 1'b1;
    tick(30);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_raw({5'b0, stp, par, d, 1'b0}, 11);
    release_line();
  endtask

  initial begin
    int n;
    logic seen;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_errs", {parity_err, frame_err}, 0);

    // 0x1C, odd parity bit 0: word appears the cycle after CHECK
    exp_q.push_back(8'h1C);
    send_raw({5'b0, 1'b1, 1'b0, 8'h1C, 1'b0}, 11);
    repeat (8) @(negedge clk);
    chk("valid_before_push", dout_valid, 0);
    @(negedge clk);
    chk("valid_after_check", dout_valid, 1);
    chk("count_after_push", fifo_count, 1);
    release_line();
    dout_ready = 1'b1;
    tick(5);
    chk("count_after_pop", fifo_count, 0);

    // bad parity
    err_q.push_back(1);
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("parity_err_no_push", fifo_count, 0);

    // bad stop bit
    err_q.push_back(2);
    send_frame(8'h55, 1'b1, 1'b0);
    chk("stop_err_no_push", fifo_count, 0);

    // timeout: start + 5 data bits, then silence
    send_raw(16'b0000_0000_0011_1010, 6);
    chk("busy_mid_frame", busy, 1);
    err_q.push_back(2);
    n = 0;
    seen = 1'b0;
    while (n < 1200 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 10) kbd_clk = 1'b1;
      seen = frame_err;
    end
    chk("timeout_latency", n, 1008);
    tick(2);
    chk("busy_after_timeout", busy, 0);
    kbd_dat = 1'b1;
    tick(20);

    // 2-cycle glitch on kbd_clk is filtered out
    kbd_clk = 1'b0;
    tick(2);
    kbd_clk = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(1); seen |= busy; end
    chk("glitch_busy", seen, 0);

    // overflow: five frames with no consumer
    dout_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h02, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1);
    send_frame(8'h04, 1'b0, 1'b1);
    chk("ovf_not_yet", overflow, 0);
    send_frame(8'h05, 1'b1, 1'b1);
    chk("ovf_count", fifo_count, 4);
    chk("ovf_sticky", overflow, 1);
    dout_ready = 1'b1;
    tick(10);
    chk("ovf_drained", exp_q.size(), 0);
    chk("ovf_count_empty", fifo_count, 0);

    // reset mid-frame discards FIFO contents and partial frame
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    chk("pre_reset_count", fifo_count, 1);
    send_raw(16'b0000_0000_0000_1010, 4);
    tick(10);
    kbd_clk = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    tick(20);
    dout_ready = 1'b1;
    exp_q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1, 1'b1);
    tick(10);

    chk("words_left", exp_q.size(), 0);
    chk("errs_left", err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
